// File: rtl/maze_pkg.sv
// maze_pkg: shared direction/state encodings, maze constants and neighbour helpers
package maze_pkg;
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;
  typedef enum logic [3:0] {IDLE, CHKSTART, MARK, PROBE, WAIT, DECIDE, BACK, DONE, FAIL, REPLAY} state_t;
  localparam logic [7:0] START = 8'h00;
  localparam logic [7:0] GOAL = 8'hFF;
  localparam int DEPTH = 256;
  function automatic logic [7:0] step(input logic [7:0] loc, input dir_t d);
    logic [3:0] x, y;
    x = loc[3:0];
    y = loc[7:4];
    return d == DIR_UP ? {y - 4'd1, x} : d == DIR_RIGHT ? {y, x + 4'd1} : d == DIR_DOWN ? {y + 4'd1, x} : {y, x - 4'd1};
  endfunction
  function automatic logic in_range(input logic [7:0] loc, input dir_t d);
    return d == DIR_UP ? loc[7:4] != 4'd0 : d == DIR_RIGHT ? loc[3:0] != 4'd15 : d == DIR_DOWN ? loc[7:4] != 4'd15 : loc[3:0] != 4'd0;
  endfunction
endpackage

// File: rtl/maze_stack.sv
// maze_stack: 256 x 2-bit move LIFO with indexed read port for path replay
module maze_stack
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  dir_t       push_dir,
  input  logic [7:0] rd_idx,
  output dir_t       top,
  output dir_t       rd_dir,
  output logic [7:0] depth,
  output logic       empty
);
  dir_t mem [DEPTH];
  // depth pointer; a new search clears it, push/pop never coincide
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) depth <= '0;
    else if (clr) depth <= '0;
    else if (push) depth <= depth + 8'd1;
    else if (pop) depth <= depth - 8'd1;
  // storage needs no reset, only entries below depth are ever read
  always_ff @(posedge clk)
    if (push) mem[depth] <= push_dir;
  assign top = mem[depth - 8'd1];
  assign rd_dir = mem[rd_idx];
  assign empty = depth == 8'd0;
endmodule

// File: rtl/maze_solver_ctrl.sv
// maze_solver_ctrl: depth-first maze search from (0,0) to (15,15) with path replay
module maze_solver_ctrl
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       run,
  output logic [7:0] mem_loc,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_din,
  input  logic       mem_dout,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic       move_valid,
  output logic [1:0] move_dir
);
  state_t state, nxt;
  dir_t dir, top, rd_dir;
  logic [7:0] loc, nbr, ridx, depth;
  logic ok, chk, blk, empty, clr, push, pop;
  assign nbr = step(loc, dir);
  assign ok = in_range(loc, dir);
  assign clr = start && (state == IDLE || state == DONE || state == FAIL);
  assign push = state == DECIDE && !blk;
  assign pop = state == BACK && !empty;
  // strobes decode straight from registered state so reset silences them at once
  assign mem_rd = state == CHKSTART || (state == PROBE && ok);
  assign mem_wr = state == MARK;
  assign mem_din = mem_wr;
  assign mem_loc = state == PROBE && ok ? nbr : (state == CHKSTART || mem_wr) ? loc : 8'h00;
  maze_stack u_stack (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop), .push_dir(dir),
    .rd_idx(ridx), .top(top), .rd_dir(rd_dir), .depth(depth), .empty(empty)
  );
  // next-state selection
  always_comb begin
    nxt = state;
    case (state)
      IDLE, FAIL: nxt = start ? CHKSTART : state;
      DONE:       nxt = start ? CHKSTART : run ? REPLAY : DONE;
      CHKSTART:   nxt = WAIT;
      WAIT:       nxt = !chk ? DECIDE : mem_dout ? FAIL : MARK;
      MARK:       nxt = PROBE;
      PROBE:      nxt = ok ? WAIT : dir == DIR_LEFT ? BACK : PROBE;
      DECIDE:     nxt = !blk ? (nbr == GOAL ? DONE : MARK) : dir == DIR_LEFT ? BACK : PROBE;
      BACK:       nxt = empty ? FAIL : top == DIR_LEFT ? BACK : PROBE;
      REPLAY:     nxt = ridx == depth - 8'd1 ? DONE : REPLAY;
      default:    nxt = IDLE;
    endcase
  end
  // state, position, probe direction and registered status/replay outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      loc <= START;
      dir <= DIR_UP;
      chk <= 1'b0;
      blk <= 1'b0;
      ridx <= 8'd0;
      busy <= 1'b0;
      done <= 1'b0;
      fail <= 1'b0;
      move_valid <= 1'b0;
      move_dir <= 2'd0;
    end else begin
      state <= nxt;
      busy <= !(nxt inside {IDLE, DONE, FAIL, REPLAY});
      done <= nxt == DONE || nxt == REPLAY;
      fail <= nxt == FAIL;
      move_valid <= state == REPLAY;
      move_dir <= state == REPLAY ? rd_dir : 2'd0;
      ridx <= state == REPLAY ? ridx + 8'd1 : 8'd0;
      if (clr) begin
        loc <= START;
        chk <= 1'b1;
      end
      case (state)
        WAIT: begin
          chk <= 1'b0;
          blk <= mem_dout;
        end
        MARK: dir <= DIR_UP;
        PROBE: if (!ok) dir <= dir_t'(dir + 2'd1);
        DECIDE: if (!blk) loc <= nbr; else dir <= dir_t'(dir + 2'd1);
        BACK: if (!empty) begin
          loc <= step(loc, dir_t'(top ^ 2'd2));
          dir <= dir_t'(top + 2'd1);
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_maze_solver_ctrl.sv
// tb_maze_solver_ctrl: randomized and directed maze searches checked against a plain DFS model
module tb_maze_solver_ctrl;
  logic clk = 0, rst_n = 0, start = 0, run = 0, mem_dout = 0;
  logic [7:0] mem_loc;
  logic mem_rd, mem_wr, mem_din, busy, done, fail, move_valid;
  logic [1:0] move_dir;
  int tests = 0, errs = 0;
  bit mem [256];
  bit stim [256];
  bit ref_maze [256];
  bit ref_ok;
  int ref_path [$];
  int got_path [$];
  int dxs [4] = '{0, 1, 0, -1};
  int dys [4] = '{-1, 0, 1, 0};
  int wr_cnt = 0, rw_both = 0, lane_bad = 0;
  bit lane_on = 0, wr_seen = 0, load = 0;
  logic [7:0] last_wr = 8'h00;

  always #5 clk = ~clk;

  maze_solver_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run(run), .mem_loc(mem_loc),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .done(done), .fail(fail), .move_valid(move_valid), .move_dir(move_dir)
  );

  // maze memory with one-cycle read latency, plus strobe monitors
  always @(posedge clk) begin
    int dx, dy;
    if (load) for (int i = 0; i < 256; i++) mem[i] = stim[i];
    if (mem_rd && mem_wr) rw_both++;
    if (lane_on && mem_rd && wr_seen) begin
      dx = int'(mem_loc[3:0]) - int'(last_wr[3:0]);
      dy = int'(mem_loc[7:4]) - int'(last_wr[7:4]);
      if ((dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy) != 1) lane_bad++;
    end
    if (mem_wr) begin
      mem[mem_loc] = mem_din;
      wr_cnt++;
      last_wr = mem_loc;
    end
    wr_seen = lane_on && (wr_seen || mem_wr);
    if (mem_rd) mem_dout <= mem[mem_loc];
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // textbook DFS over the maze: try up/right/down/left, mark visited, backtrack on dead ends
  task automatic ref_solve();
    int cx, cy, nx, ny, d;
    int st [$];
    ref_ok = 0;
    ref_path.delete();
    for (int i = 0; i < 256; i++) ref_maze[i] = stim[i];
    if (ref_maze[0]) return;
    ref_maze[0] = 1;
    cx = 0; cy = 0; d = 0;
    for (int n = 0; n < 5000; n++) begin
      if (d == 4) begin
        if (st.size() == 0) return;
        d = st.pop_back();
        cx -= dxs[d];
        cy -= dys[d];
        d++;
      end else begin
        nx = cx + dxs[d];
        ny = cy + dys[d];
        if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !ref_maze[ny * 16 + nx]) begin
          st.push_back(d);
          cx = nx; cy = ny;
          if (cx == 15 && cy == 15) begin
            ref_ok = 1;
            ref_path = st;
            return;
          end
          ref_maze[cy * 16 + cx] = 1;
          d = 0;
        end else d++;
      end
    end
  endtask

  task automatic load_maze();
    @(negedge clk) load = 1;
    @(negedge clk) load = 0;
    ref_solve();
  endtask

  task automatic search(input bit poke, output int cyc);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    cyc = 1;
    while (busy && cyc < 20000) begin
      if (poke) start = (cyc % 5 == 2);
      @(negedge clk);
      cyc++;
    end
    start = 0;
    if (busy) check("search_timeout", 1, 0);
  endtask

  task automatic replay();
    bit seen = 0;
    got_path.delete();
    @(negedge clk) run = 1;
    @(negedge clk) run = 0;
    for (int i = 0; i < 300; i++) begin
      if (move_valid) begin
        got_path.push_back(int'(move_dir));
        seen = 1;
      end else if (seen) break;
      @(negedge clk);
    end
  endtask

  task automatic verify(input string tag);
    int bad = 0;
    check({tag, "_done"}, done, ref_ok);
    check({tag, "_fail"}, fail, !ref_ok);
    for (int i = 0; i < 256; i++) if (mem[i] != ref_maze[i]) bad++;
    check({tag, "_maze"}, bad, 0);
    if (ref_ok) begin
      replay();
      bad = 0;
      check({tag, "_depth"}, got_path.size(), ref_path.size());
      for (int i = 0; i < got_path.size() && i < ref_path.size(); i++) if (got_path[i] != ref_path[i]) bad++;
      check({tag, "_path"}, bad, 0);
      check({tag, "_redone"}, done, 1);
    end
  endtask

  initial begin
    int cyc, w0, bad;
    repeat (2) @(negedge clk);
    check("rst_outputs", {mem_loc, mem_rd, mem_wr, mem_din, busy, done, fail, move_valid, move_dir}, 0);
    rst_n = 1;

    // open maze: straight right then straight down
    for (int i = 0; i < 256; i++) stim[i] = 0;
    load_maze();
    search(0, cyc);
    verify("open");
    check("open_len30", got_path.size(), 30);
    bad = 0;
    for (int i = 0; i < got_path.size(); i++) if (got_path[i] != (i < 15 ? 1 : 2)) bad++;
    check("open_dirs", bad, 0);

    // blocked start cell
    stim[0] = 1;
    load_maze();
    w0 = wr_cnt;
    search(0, cyc);
    check("start_wall_fail", fail, 1);
    check("start_wall_lat", cyc <= 3, 1);
    check("start_wall_nowr", wr_cnt - w0, 0);
    @(negedge clk) run = 1;
    @(negedge clk) run = 0;
    bad = 0;
    repeat (4) @(negedge clk) if (move_valid || !fail) bad++;
    check("run_in_fail", bad, 0);

    // goal enclosed
    for (int i = 0; i < 256; i++) stim[i] = 0;
    stim[254] = 1;
    stim[239] = 1;
    load_maze();
    search(0, cyc);
    verify("walled");
    bad = 0;
    for (int i = 0; i < 256; i++) bad += mem[i];
    check("walled_ones", bad, 255);

    // serpentine single lane
    for (int r = 0; r < 16; r++)
      for (int x = 0; x < 16; x++)
        stim[r * 16 + x] = (r % 2 == 1) && (x != (((r >> 1) & 1) ? 0 : 15));
    stim[255] = 0;
    load_maze();
    lane_on = 1;
    search(0, cyc);
    lane_on = 0;
    verify("lane");
    check("lane_adjacent", lane_bad, 0);

    // reset mid-search, then a clean rerun
    for (int i = 0; i < 256; i++) stim[i] = 0;
    load_maze();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (15) @(negedge clk);
    #1 rst_n = 0;
    #1 check("midrst_outputs", {mem_loc, mem_rd, mem_wr, mem_din, busy, done, fail, move_valid, move_dir}, 0);
    repeat (2) @(negedge clk);
    check("midrst_quiet", {mem_rd, mem_wr, busy}, 0);
    rst_n = 1;
    load_maze();
    search(0, cyc);
    verify("after_rst");

    // start pulses during a search must not disturb it
    for (int i = 0; i < 256; i++) stim[i] = ($urandom_range(99) < 25);
    stim[0] = 0;
    stim[255] = 0;
    load_maze();
    search(1, cyc);
    verify("poked");

    // random mazes
    for (int t = 0; t < 10; t++) begin
      int dens = $urandom_range(15, 40);
      for (int i = 0; i < 256; i++) stim[i] = ($urandom_range(99) < dens);
      stim[0] = ($urandom_range(15) == 0);
      stim[255] = 0;
      load_maze();
      search(0, cyc);
      verify($sformatf("rand%0d", t));
    end

    check("rd_wr_exclusive", rw_both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
